// File: rtl/irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// irq_controller_pkg
//   Shared definitions for the interrupt front end: the default source count
//   and the request-handshake state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package irq_controller_pkg;

    // Default number of interrupt sources (power of two, >= 2).
    localparam int DEFAULT_N = 32;

    // Handshake state. The encodings are fixed so that CP0 debug readback
    // and any external observers see stable values.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage : irq_controller_pkg

// File: rtl/irq_controller_pp_or.sv
// -----------------------------------------------------------------------------
// pp_or
//   Prefix OR across a vector, from index 0 upward:
//   o_prefix[i] = |i_vec[i:0]. Purely combinational.
//   Ports:
//     i_vec     in   N   input vector
//     o_prefix  out  N   running OR starting at bit 0
// -----------------------------------------------------------------------------
module pp_or #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_prefix
);

    // A separate accumulator avoids the vector depending on its own bits,
    // which simulators treat as a combinational self-loop.
    logic w_acc;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_acc    = 1'b0;
        o_prefix = '0;
        for (int i = 0; i < N; i++) begin
            w_acc       = w_acc | i_vec[i];
            o_prefix[i] = w_acc;
        end
    end

endmodule : pp_or

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Interrupt front end for the MIPS core. Registers N raw lines, latches
//   rising edges (or follows levels) into a pending register, applies a
//   software mask and presents the lowest-index pending source to the CPU
//   under a req/ack/eoi handshake.
//   Ports:
//     clk         in   1   system clock, rising edge
//     reset       in   1   synchronous active-high reset, clears all state
//     irq_in      in   N   raw interrupt lines
//     mask_we     in   1   mask register write enable
//     mask_wdata  in   N   new mask value (1 = source enabled)
//     mask_q      out  N   current mask register
//     pending_q   out  N   current pending register (before masking)
//     int_req     out  1   interrupt request to the CPU
//     int_id      out  W   index of the requested source
//     int_onehot  out  N   one-hot of int_id, zero when no request is held
//     int_ack     in   1   CPU accepts the request (only honoured in REQ)
//     eoi         in   1   end of interrupt (only honoured in SERVICE)
// -----------------------------------------------------------------------------
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int           N         = DEFAULT_N,
    parameter logic [N-1:0] EDGE_MASK = {N{1'b1}},
    localparam int          W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] irq_in,
    input  logic         mask_we,
    input  logic [N-1:0] mask_wdata,
    output logic [N-1:0] mask_q,
    output logic [N-1:0] pending_q,
    output logic         int_req,
    output logic [W-1:0] int_id,
    output logic [N-1:0] int_onehot,
    input  logic         int_ack,
    input  logic         eoi
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [N-1:0] r_sync_q;
    logic [N-1:0] r_prev_q;
    logic [N-1:0] r_pending_q;
    logic [N-1:0] r_mask_q;
    logic [N-1:0] r_onehot_q;
    logic [W-1:0] r_id_q;
    state_e       r_state;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [N-1:0] w_cand;
    logic [N-1:0] w_prefix;
    logic [N-1:0] w_win;
    logic [W-1:0] w_win_id;
    logic [N-1:0] w_edge;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pending_next;
    logic         w_ack_take;
    logic         w_held_live;
    state_e       w_state_next;

    // ------------------------------------------------------------------
    // Arbitration: lowest enabled pending index wins. Only registered
    // values feed this, so a mask write takes effect one cycle later.
    // ------------------------------------------------------------------
    assign w_cand = r_pending_q & r_mask_q;

    pp_or #(.N(N)) u_pp_or (
        .i_vec    (w_cand),
        .o_prefix (w_prefix)
    );

    // The first position where the prefix turns on is the winner.
    assign w_win = w_prefix & ~(w_prefix << 1);

    always_comb begin
        w_win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win[i]) begin
                w_win_id = W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending update
    // ------------------------------------------------------------------
    assign w_ack_take  = (r_state == ST_REQ) && int_ack;
    // Is the source currently offered to the CPU still enabled and pending?
    assign w_held_live = |(w_cand & r_onehot_q);
    assign w_edge      = r_sync_q & ~r_prev_q;
    assign w_clr       = w_ack_take ? r_onehot_q : '0;

    // Edge bits: a new edge is OR-ed in after the ack clear, so a set and a
    // clear landing together keep the bit set. Level bits mirror the line.
    assign w_pending_next = (EDGE_MASK & (w_edge | (r_pending_q & ~w_clr)))
                          | (~EDGE_MASK & r_sync_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|w_cand) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack beats withdraw when both happen in the same cycle.
                if (int_ack) begin
                    w_state_next = ST_SERVICE;
                end else if (!w_held_live) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        int_req = (r_state == ST_REQ);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q    <= '0;
            r_prev_q    <= '0;
            r_pending_q <= '0;
            r_mask_q    <= '0;
            r_onehot_q  <= '0;
            r_id_q      <= '0;
        end else begin
            r_sync_q    <= irq_in;
            r_prev_q    <= r_sync_q;
            r_pending_q <= w_pending_next;

            if (mask_we) begin
                r_mask_q <= mask_wdata;
            end

            case (r_state)
                ST_IDLE: begin
                    // Latch the winner once; it stays fixed for the whole
                    // request so a later higher-priority source cannot preempt.
                    if (|w_cand) begin
                        r_id_q     <= w_win_id;
                        r_onehot_q <= w_win;
                    end
                end
                ST_REQ: begin
                    if (!int_ack && !w_held_live) begin
                        r_onehot_q <= '0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        r_onehot_q <= '0;
                    end
                end
                default: begin
                    r_onehot_q <= '0;
                end
            endcase
        end
    end

    assign mask_q     = r_mask_q;
    assign pending_q  = r_pending_q;
    assign int_id     = r_id_q;
    assign int_onehot = r_onehot_q;

endmodule : irq_controller

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//   Directed bench for irq_controller (N = 32, source 9 level-sensitive).
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    localparam int          N  = 32;
    localparam int          W  = 5;
    localparam logic [31:0] EM = 32'hFFFF_FDFF;

    logic         clk;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic [N-1:0] mask_q;
    logic [N-1:0] pending_q;
    logic         int_req;
    logic [W-1:0] int_id;
    logic [N-1:0] int_onehot;
    logic         int_ack;
    logic         eoi;

    int checks   = 0;
    int failures = 0;

    irq_controller #(.N(N), .EDGE_MASK(EM)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_q     (mask_q),
        .pending_q  (pending_q),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_onehot (int_onehot),
        .int_ack    (int_ack),
        .eoi        (eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] irq;
        logic        mwe;
        logic [31:0] mwd;
        logic        ack;
        logic        eoi;
        logic        req;
        logic [31:0] id;
        logic [31:0] oh;
        logic [31:0] pend;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs set beforehand are captured on the rising edge,
    // outputs are then stable at the following falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        mask_we    = 1'b0;
        mask_wdata = '0;
        int_ack    = 1'b0;
        eoi        = 1'b0;
    endtask

    task automatic check_req(input string name, input logic req, input logic [31:0] id,
                             input logic [31:0] oh);
        check({name, ".req"}, {31'd0, int_req}, {31'd0, req});
        check({name, ".id"}, {27'd0, int_id}, id);
        check({name, ".onehot"}, int_onehot, oh);
    endtask

    initial begin
        // Test 1: single edge on source 0.
        vecs[0]  = '{32'h0,         1, 32'h1,         0, 0, 0,  0, 32'h0,       32'h0,         32'h1};
        vecs[1]  = '{32'h1,         0, 32'h0,         0, 0, 0,  0, 32'h0,       32'h0,         32'h1};
        vecs[2]  = '{32'h0,         0, 32'h0,         0, 0, 0,  0, 32'h0,       32'h1,         32'h1};
        vecs[3]  = '{32'h0,         0, 32'h0,         0, 0, 1,  0, 32'h1,       32'h1,         32'h1};
        vecs[4]  = '{32'h0,         0, 32'h0,         1, 0, 0,  0, 32'h1,       32'h0,         32'h1};
        vecs[5]  = '{32'h0,         0, 32'h0,         0, 1, 0,  0, 32'h0,       32'h0,         32'h1};
        // Test 2: sources 5 and 17 together; 5 first, 17 after one idle cycle.
        vecs[6]  = '{32'h0,         1, 32'hFFFF_FFFF, 0, 0, 0,  0, 32'h0,       32'h0,         32'hFFFF_FFFF};
        vecs[7]  = '{32'h0002_0020, 0, 32'h0,         0, 0, 0,  0, 32'h0,       32'h0,         32'hFFFF_FFFF};
        vecs[8]  = '{32'h0002_0020, 0, 32'h0,         0, 0, 0,  0, 32'h0,       32'h0002_0020, 32'hFFFF_FFFF};
        vecs[9]  = '{32'h0002_0020, 0, 32'h0,         0, 0, 1,  5, 32'h20,      32'h0002_0020, 32'hFFFF_FFFF};
        vecs[10] = '{32'h0002_0020, 0, 32'h0,         1, 0, 0,  5, 32'h20,      32'h0002_0000, 32'hFFFF_FFFF};
        vecs[11] = '{32'h0002_0020, 0, 32'h0,         0, 1, 0,  5, 32'h0,       32'h0002_0000, 32'hFFFF_FFFF};
        vecs[12] = '{32'h0002_0020, 0, 32'h0,         0, 0, 1, 17, 32'h2_0000,  32'h0002_0000, 32'hFFFF_FFFF};
        vecs[13] = '{32'h0002_0020, 0, 32'h0,         1, 0, 0, 17, 32'h2_0000,  32'h0,         32'hFFFF_FFFF};
        vecs[14] = '{32'h0,         0, 32'h0,         0, 1, 0, 17, 32'h0,       32'h0,         32'hFFFF_FFFF};

        reset  = 1'b1;
        irq_in = '0;
        clear_inputs();
        repeat (2) cyc();
        check_req("reset", 1'b0, 0, 32'h0);
        check("reset.pending", pending_q, 32'h0);
        check("reset.mask", mask_q, 32'h0);
        reset = 1'b0;

        // Table-driven part: tests 1 and 2.
        for (int i = 0; i < 15; i++) begin
            irq_in     = vecs[i].irq;
            mask_we    = vecs[i].mwe;
            mask_wdata = vecs[i].mwd;
            int_ack    = vecs[i].ack;
            eoi        = vecs[i].eoi;
            cyc();
            check_req($sformatf("v%0d", i), vecs[i].req, vecs[i].id, vecs[i].oh);
            check($sformatf("v%0d.pending", i), pending_q, vecs[i].pend);
            check($sformatf("v%0d.mask", i), mask_q, vecs[i].mask);
        end
        clear_inputs();
        irq_in = '0;

        // Test 3: mask removed while REQ on id 3 -> withdraw, pending kept.
        irq_in = 32'h8; cyc();
        irq_in = '0;    cyc();
        cyc();
        check_req("t3.req", 1'b1, 3, 32'h8);
        mask_we = 1'b1; mask_wdata = 32'h0; cyc();
        clear_inputs();
        check_req("t3.mask_edge", 1'b1, 3, 32'h8);
        cyc();
        check_req("t3.withdrawn", 1'b0, 3, 32'h0);
        check("t3.pending", pending_q, 32'h8);
        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF; cyc();
        clear_inputs();
        cyc();
        check_req("t3.rereq", 1'b1, 3, 32'h8);
        int_ack = 1'b1; cyc(); clear_inputs();
        eoi = 1'b1;     cyc(); clear_inputs();
        check("t3.cleared", pending_q, 32'h0);

        // Test 4: higher-priority edge during REQ does not preempt.
        irq_in = 32'h100; cyc();
        irq_in = '0;      cyc();
        cyc();
        check_req("t4.req8", 1'b1, 8, 32'h100);
        irq_in = 32'h4; cyc();
        irq_in = '0;    cyc();
        check_req("t4.no_preempt", 1'b1, 8, 32'h100);
        check("t4.pending", pending_q, 32'h104);
        int_ack = 1'b1; cyc(); clear_inputs();
        check_req("t4.service", 1'b0, 8, 32'h100);
        check("t4.pending_ack", pending_q, 32'h4);
        eoi = 1'b1; cyc(); clear_inputs();
        check_req("t4.idle", 1'b0, 8, 32'h0);
        cyc();
        check_req("t4.req2", 1'b1, 2, 32'h4);
        int_ack = 1'b1; cyc(); clear_inputs();
        eoi = 1'b1;     cyc(); clear_inputs();

        // Test 5: new edge on id 4 in the same cycle as its ack -> set wins.
        irq_in = 32'h10; cyc();
        irq_in = '0;     cyc();
        cyc();
        check_req("t5.req4", 1'b1, 4, 32'h10);
        irq_in = 32'h10; cyc();
        int_ack = 1'b1;  cyc(); clear_inputs();
        irq_in = '0;
        check("t5.pending_kept", pending_q, 32'h10);
        check_req("t5.service", 1'b0, 4, 32'h10);
        eoi = 1'b1; cyc(); clear_inputs();
        cyc();
        check_req("t5.rereq", 1'b1, 4, 32'h10);
        int_ack = 1'b1; cyc(); clear_inputs();
        eoi = 1'b1;     cyc(); clear_inputs();
        check("t5.cleared", pending_q, 32'h0);

        // Test 6: level source 9 held high survives ack, then reset in SERVICE.
        irq_in = 32'h200; cyc();
        cyc();
        check("t6.level_pending", pending_q, 32'h200);
        cyc();
        check_req("t6.req9", 1'b1, 9, 32'h200);
        int_ack = 1'b1; cyc(); clear_inputs();
        check("t6.level_after_ack", pending_q, 32'h200);
        eoi = 1'b1; cyc(); clear_inputs();
        cyc();
        check_req("t6.rereq9", 1'b1, 9, 32'h200);
        int_ack = 1'b1; cyc(); clear_inputs();
        check_req("t6.service", 1'b0, 9, 32'h200);
        reset  = 1'b1;
        irq_in = '0;
        cyc();
        check_req("t6.reset", 1'b0, 0, 32'h0);
        check("t6.reset_pending", pending_q, 32'h0);
        check("t6.reset_mask", mask_q, 32'h0);
        reset = 1'b0;
        cyc();
        check_req("t6.after_reset", 1'b0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_irq_controller
